// File: rtl/shift_unit.sv
// Two-stage pipelined shift/rotate unit.
// Every op is built as a rotation (upper amount bits in stage 1, lower bits in
// stage 2), then masked/sign-filled in stage 2 for the logical and arithmetic
// shifts. Carry falls out of the rotated word: the last bit moved out of the
// word is the bit that wrapped into position 0 (left) or WIDTH-1 (right).
module shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5,
  parameter int unsigned TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAGW-1:0]  out_tag
);

  localparam logic [2:0] OpSll = 3'd0;
  localparam logic [2:0] OpSrl = 3'd1;
  localparam logic [2:0] OpSra = 3'd2;
  localparam logic [2:0] OpRol = 3'd3;
  localparam logic [2:0] OpRor = 3'd4;

  // Stage 2 handles amount bits [LoBits-1:0], stage 1 the rest.
  localparam int unsigned    LoBits = SHW / 2;
  localparam logic [SHW-1:0] LoMask = SHW'((1 << LoBits) - 1);
  localparam logic [SHW-1:0] HiMask = ~LoMask;
  localparam logic [WIDTH-1:0] Ones = '1;

  // Log-level rotator; levels whose amount bit is masked to 0 reduce to wires.
  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] d,
                                               input logic [SHW-1:0]   amt,
                                               input logic             left);
    logic [WIDTH-1:0] r;
    r = d;
    for (int unsigned k = 0; k < SHW; k++) begin
      if (amt[k]) begin
        if (left) r = (r << (1 << k)) | (r >> (WIDTH - (1 << k)));
        else      r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake / pipeline control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_free;
  logic s1_load;
  logic s2_load;

  // in_ready may follow out_ready combinationally; nothing else crosses.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_free;
    s1_load  = in_valid && in_ready;
    s2_load  = s1_valid_q && s2_free;
  end

  // Next-state of the two valid bits.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s2_free) s2_valid_d = s1_valid_q;
    if (s1_load) s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  // Valid bits for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: decode and coarse rotation
  // ---------------------------------------------------------------------------
  logic             in_illegal;
  logic             in_left;
  logic [SHW-1:0]   in_amt_eff;
  logic [WIDTH-1:0] s1_data_d;

  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [SHW-1:0]   s1_amt_q;
  logic [TAGW-1:0]  s1_tag_q;
  logic             s1_left_q;
  logic             s1_sign_q;
  logic             s1_illegal_q;

  // Illegal ops rotate by zero so the operand passes through untouched.
  always_comb begin
    in_illegal = (in_op > OpRor);
    in_left    = (in_op == OpSll) || (in_op == OpRol);
    in_amt_eff = in_illegal ? '0 : in_amt;
    s1_data_d  = rotate(in_data, in_amt_eff & HiMask, in_left);
  end

  // Stage 1 registers, loaded on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op_q      <= '0;
      s1_data_q    <= '0;
      s1_amt_q     <= '0;
      s1_tag_q     <= '0;
      s1_left_q    <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_illegal_q <= 1'b0;
    end else if (s1_load) begin
      s1_op_q      <= in_op;
      s1_data_q    <= s1_data_d;
      s1_amt_q     <= in_amt_eff;
      s1_tag_q     <= in_tag;
      s1_left_q    <= in_left;
      s1_sign_q    <= in_data[WIDTH-1];
      s1_illegal_q <= in_illegal;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fine rotation, masking, flags
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] mask_l;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] s2_data_d;
  logic             s2_carry_d;

  logic [WIDTH-1:0] s2_data_q;
  logic             s2_carry_q;
  logic             s2_zero_q;
  logic             s2_illegal_q;
  logic [TAGW-1:0]  s2_tag_q;

  // Finish the rotation, then clear or sign-fill the vacated bits.
  always_comb begin
    rot        = rotate(s1_data_q, s1_amt_q & LoMask, s1_left_q);
    mask_l     = Ones << s1_amt_q;
    mask_r     = Ones >> s1_amt_q;
    s2_carry_d = (s1_amt_q != '0) && (s1_left_q ? rot[0] : rot[WIDTH-1]);
    unique case (s1_op_q)
      OpSll:   s2_data_d = rot & mask_l;
      OpSrl:   s2_data_d = rot & mask_r;
      OpSra:   s2_data_d = (rot & mask_r) | ({WIDTH{s1_sign_q}} & ~mask_r);
      OpRol:   s2_data_d = rot;
      OpRor:   s2_data_d = rot;
      default: s2_data_d = rot;
    endcase
  end

  // Stage 2 registers drive the outputs; they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data_q    <= '0;
      s2_carry_q   <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
    end else if (s2_load) begin
      s2_data_q    <= s2_data_d;
      s2_carry_q   <= s2_carry_d;
      s2_zero_q    <= (s2_data_d == '0);
      s2_illegal_q <= s1_illegal_q;
      s2_tag_q     <= s1_tag_q;
    end
  end

  // Output wiring from stage 2 state.
  always_comb begin
    out_valid   = s2_valid_q;
    out_data    = s2_data_q;
    out_carry   = s2_carry_q;
    out_zero    = s2_zero_q;
    out_illegal = s2_illegal_q;
    out_tag     = s2_tag_q;
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases, random back-to-back
// traffic, backpressure and mid-flight reset against an arithmetic model.
module tb_shift_unit;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          carry;
    logic          zero;
    logic          illegal;
    logic [TW-1:0] tag;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          out_illegal;
  logic [TW-1:0] out_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  logic stall_prev = 1'b0;
  res_t held;

  shift_unit #(.WIDTH(W), .SHW(SW), .TAGW(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_illegal(out_illegal),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: straight arithmetic on the operand.
  function automatic res_t ref_model(input logic [2:0] op, input logic [W-1:0] d,
                                     input logic [SW-1:0] a, input logic [TW-1:0] t);
    res_t r;
    int   n;
    n         = int'(a);
    r.tag     = t;
    r.illegal = 1'b0;
    r.carry   = 1'b0;
    case (op)
      3'd0: begin r.data = d << n; if (n != 0) r.carry = d[W-n]; end
      3'd1: begin r.data = d >> n; if (n != 0) r.carry = d[n-1]; end
      3'd2: begin r.data = $signed(d) >>> n; if (n != 0) r.carry = d[n-1]; end
      3'd3: begin r.data = (d << n) | (d >> (W - n)); if (n != 0) r.carry = d[W-n]; end
      3'd4: begin r.data = (d >> n) | (d << (W - n)); if (n != 0) r.carry = d[n-1]; end
      default: begin r.data = d; r.illegal = 1'b1; end
    endcase
    r.zero = (r.data == '0);
    return r;
  endfunction

  // Scoreboard: handshakes are sampled mid-cycle and take effect at the next edge.
  always @(negedge clk) begin
    res_t got;
    got = {out_data, out_carry, out_zero, out_illegal, out_tag};
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_out", 64'(got), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", 64'd1, 64'd0);
        else check_eq("result", 64'(got), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_op, in_data, in_amt, in_tag));
      stall_prev = out_valid && !out_ready;
      held       = got;
    end
  end

  // One op into an empty pipe; checks latency and the result against constants.
  task automatic run_one(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] a,
                         input logic [TW-1:0] t, input logic [W-1:0] ed, input logic ec,
                         input logic ez, input logic ei);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; in_tag = t; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("dir_data", 64'(out_data), 64'(ed));
    check_eq("dir_carry", 64'(out_carry), 64'(ec));
    check_eq("dir_zero", 64'(out_zero), 64'(ez));
    check_eq("dir_illegal", 64'(out_illegal), 64'(ei));
    check_eq("dir_tag", 64'(out_tag), 64'(t));
  endtask

  logic [2:0]    st_op[5];
  logic [W-1:0]  st_data[5];
  logic [SW-1:0] st_amt[5];

  task automatic drive_item(input int k);
    in_op   = st_op[k];
    in_data = st_data[k];
    in_amt  = st_amt[k];
    in_tag  = TW'(8 + k);
  endtask

  initial begin
    int   k;
    int   acc_n;
    logic acc;
    bit   done;

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_amt = '0; in_tag = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_outs", 64'({out_data, out_carry, out_zero, out_illegal, out_tag}), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed cases.
    run_one(3'd2, 32'h8000_0000, 5'd4,  4'd3, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    run_one(3'd1, 32'h8000_0000, 5'd4,  4'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    run_one(3'd3, 32'h8000_0001, 5'd1,  4'd5, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    run_one(3'd4, 32'h0000_0001, 5'd1,  4'd6, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_one(3'd0, 32'h0000_000F, 5'd28, 4'd7, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
    run_one(3'd0, 32'h8000_0000, 5'd1,  4'd8, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    for (int op = 0; op < 5; op++)
      run_one(3'(op), 32'h1234_5678, 5'd0, 4'(op), 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    run_one(3'd6, 32'h1234_5678, 5'd13, 4'd9, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    run_one(3'd7, 32'h0000_0000, 5'd31, 4'd10, 32'h0000_0000, 1'b0, 1'b1, 1'b1);

    // 16 random ops back to back; results must emerge on consecutive cycles.
    for (int j = 0; j < 18; j++) begin
      @(posedge clk); #1;
      if (j < 16) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom_range(0, 7));
        in_data  = $urandom;
        in_amt   = 5'($urandom_range(0, W - 1));
        in_tag   = 4'(j);
      end else begin
        in_valid = 1'b0;
      end
      if (j >= 2) begin
        @(negedge clk);
        check_eq("b2b_valid", 64'(out_valid), 64'd1);
        check_eq("b2b_tag", 64'(out_tag), 64'(j - 2));
      end
    end

    // Backpressure: only two ops fit while the consumer stalls.
    for (int i = 0; i < 5; i++) begin
      st_op[i]   = 3'($urandom_range(0, 4));
      st_data[i] = $urandom;
      st_amt[i]  = 5'($urandom_range(0, W - 1));
    end
    @(posedge clk); #1;
    out_ready = 1'b0; k = 0; drive_item(k); in_valid = 1'b1; acc_n = 0;
    repeat (5) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_n++;
      @(posedge clk); #1;
      if (acc) begin k++; drive_item(k); end
    end
    check_eq("stall_accepts", 64'(acc_n), 64'd2);
    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    check_eq("stall_valid", 64'(out_valid), 64'd1);
    check_eq("stall_head_tag", 64'(out_tag), 64'd8);
    out_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      check_eq("drain_in_ready", 64'(in_ready), 64'd1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 5) drive_item(k);
        else begin in_valid = 1'b0; done = 1'b1; end
      end
    end
    check_eq("drain_done", 64'(done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd3; in_data = 32'hDEAD_BEEF; in_amt = 5'd7; in_tag = 4'd1;
    @(posedge clk); #1;
    in_op = 3'd2; in_data = 32'h8765_4321; in_amt = 5'd9; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_outs", 64'({out_data, out_carry, out_zero, out_illegal, out_tag}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("no_stale", 64'(out_valid), 64'd0);
    end
    run_one(3'd4, 32'h0000_00F0, 5'd4, 4'd11, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    run_one(3'd2, 32'h7FFF_FFFF, 5'd31, 4'd12, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
